// File: rtl/conv_pkg.sv
// Shared definitions for the convolutional encoder family: default code
// constants, FSM state types and the generic symbol function.
package conv_pkg;

  localparam int MAX_K = 9;
  localparam int MAX_N = 4;
  localparam int K_DEF = 3;
  localparam int N_DEF = 2;
  localparam logic [5:0] G_75 = {3'b101, 3'b111};

  typedef enum logic {S_DATA, S_TAIL} conv_state_e;

  // Whole FSM state kept in one struct so checkers can bind to a single signal.
  typedef struct packed {
    conv_state_e state;
    logic [3:0]  tail_cnt;
  } conv_fsm_t;

  // Slice i of g (k bits at i*k) is ANDed with the window and XOR-reduced.
  // The window is zero above bit k-1, so bits of the neighbouring slice drop out.
  function automatic logic [MAX_N-1:0] conv_sym(input logic [MAX_K-1:0]       window,
                                               input logic [MAX_N*MAX_K-1:0] g,
                                               input int                     k,
                                               input int                     n);
    logic [MAX_N-1:0] sym;
    logic [MAX_K-1:0] slice;
    sym = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        slice = MAX_K'(g >> (i * k));
        sym   = sym | (MAX_N'(^(slice & window)) << i);
      end
    end
    return sym;
  endfunction

endpackage

// File: rtl/conv_branch_metric_gen.sv
// Combinational symbol generator: maps a K-bit window {u, sr} to the N-bit
// code symbol. Shared with the Viterbi branch-metric unit.
module conv_branch_metric_gen
  import conv_pkg::*;
#(
  parameter int           K = K_DEF,
  parameter int           N = N_DEF,
  parameter logic [N*K-1:0] G = G_75
) (
  input  logic [K-1:0] window,
  output logic [N-1:0] sym
);

  logic [MAX_K-1:0]       window_ext;
  logic [MAX_N*MAX_K-1:0] g_ext;
  logic [MAX_N-1:0]       sym_full;

  always_comb begin
    window_ext          = '0;
    window_ext[K-1:0]   = window;
    g_ext               = '0;
    g_ext[N*K-1:0]      = G;
    sym_full            = conv_sym(window_ext, g_ext, K, N);
  end

  assign sym = sym_full[N-1:0];

  if (N < MAX_N) begin : g_hi
    logic unused_sym_hi;
    assign unused_sym_hi = ^sym_full[MAX_N-1:N];
  end

endmodule

// File: rtl/conv_encoder_param.sv
// Rate-1/N, constraint-length-K convolutional encoder with framed valid/ready
// streams, optional zero-tail termination and a completed-frame counter.
module conv_encoder_param
  import conv_pkg::*;
#(
  parameter int             K         = K_DEF,
  parameter int             N         = N_DEF,
  parameter logic [N*K-1:0] G         = G_75,
  parameter bit             TERMINATE = 1'b1,
  parameter int             CNT_W     = 16
) (
  input  logic             clk20M_sig,
  input  logic             reset_sig,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sym,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  if (K < 2 || K > MAX_K || N < 2 || N > MAX_N) begin : g_bad_param
    $error("conv_encoder_param: K must be 2..9 and N must be 2..4");
  end

  localparam int SW = K - 1;

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and a valid output holds its payload
  // stable until it is taken.
  conv_fsm_t        fsm_q, fsm_d;
  logic [SW-1:0]    sr_q, sr_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_sym_q, out_sym_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic             advance;
  logic             take;
  logic             tail_step;
  logic             frame_done;
  logic             u;
  logic [K-1:0]     window;
  logic [SW-1:0]    sr_shift;
  logic [N-1:0]     sym;

  always_comb begin
    advance    = !out_valid_q || out_ready;
    in_ready   = !reset_sig && (fsm_q.state == S_DATA) && advance;
    take       = in_valid && in_ready;
    tail_step  = (fsm_q.state == S_TAIL) && advance;
    frame_done = out_valid_q && out_ready && out_last_q;
    u          = (fsm_q.state == S_TAIL) ? 1'b0 : in_bit;
    window     = {u, sr_q};
    sr_shift   = window[K-1:1];
  end

  conv_branch_metric_gen #(
    .K (K),
    .N (N),
    .G (G)
  ) u_gen (
    .window (window),
    .sym    (sym)
  );

  always_comb begin
    fsm_d       = fsm_q;
    sr_d        = sr_q;
    out_valid_d = out_valid_q;
    out_sym_d   = out_sym_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;

    if (advance) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (take) begin
      out_valid_d = 1'b1;
      out_sym_d   = sym;
      sr_d        = sr_shift;
      if (in_last) begin
        if (TERMINATE) begin
          fsm_d.state    = S_TAIL;
          fsm_d.tail_cnt = 4'(K - 1);
        end else begin
          out_last_d = 1'b1;
          sr_d       = '0;
        end
      end
    end else if (tail_step) begin
      out_valid_d    = 1'b1;
      out_sym_d      = sym;
      sr_d           = sr_shift;
      fsm_d.tail_cnt = fsm_q.tail_cnt - 4'd1;
      // After K-1 zero shifts sr_shift is already all-zero here.
      if (fsm_q.tail_cnt == 4'd1) begin
        out_last_d  = 1'b1;
        fsm_d.state = S_DATA;
      end
    end

    if (frame_done) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
      busy_d      = 1'b0;
    end
    // A new frame starting in the same cycle keeps busy asserted.
    if (take) begin
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk20M_sig) begin
    if (reset_sig) begin
      fsm_q       <= '{state: S_DATA, tail_cnt: 4'd0};
      sr_q        <= '0;
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      sr_q        <= sr_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_conv_encoder_param.sv
// Directed and randomized checks of conv_encoder_param across four parameter
// sets sharing one stimulus stream; a selector picks the instance under test.
module tb_conv_encoder_param;

  localparam logic [5:0]  G_A = {3'b101, 3'b111};
  localparam logic [13:0] G_C = {7'o133, 7'o171};

  // ---------------- clock / reset ----------------
  logic clk20M_sig = 1'b0;
  logic reset_sig  = 1'b1;
  logic in_valid   = 1'b0;
  logic in_bit     = 1'b0;
  logic in_last    = 1'b0;
  logic out_ready  = 1'b0;

  always #25 clk20M_sig = ~clk20M_sig;

  logic [3:0]  in_ready_w, out_valid_w, out_last_w, busy_w;
  logic [1:0]  out_sym_w [4];
  logic [15:0] frame_cnt_a, frame_cnt_b, frame_cnt_c;
  logic [1:0]  frame_cnt_d;

  conv_encoder_param #(.K(3), .N(2), .G(G_A), .TERMINATE(1'b1), .CNT_W(16)) dut_a (
    .clk20M_sig(clk20M_sig), .reset_sig(reset_sig), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .out_sym(out_sym_w[0]), .out_last(out_last_w[0]), .busy(busy_w[0]), .frame_cnt(frame_cnt_a));

  conv_encoder_param #(.K(3), .N(2), .G(G_A), .TERMINATE(1'b0), .CNT_W(16)) dut_b (
    .clk20M_sig(clk20M_sig), .reset_sig(reset_sig), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .out_sym(out_sym_w[1]), .out_last(out_last_w[1]), .busy(busy_w[1]), .frame_cnt(frame_cnt_b));

  conv_encoder_param #(.K(7), .N(2), .G(G_C), .TERMINATE(1'b1), .CNT_W(16)) dut_c (
    .clk20M_sig(clk20M_sig), .reset_sig(reset_sig), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .out_sym(out_sym_w[2]), .out_last(out_last_w[2]), .busy(busy_w[2]), .frame_cnt(frame_cnt_c));

  conv_encoder_param #(.K(3), .N(2), .G(G_A), .TERMINATE(1'b1), .CNT_W(2)) dut_d (
    .clk20M_sig(clk20M_sig), .reset_sig(reset_sig), .in_valid(in_valid), .in_ready(in_ready_w[3]),
    .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid_w[3]), .out_ready(out_ready),
    .out_sym(out_sym_w[3]), .out_last(out_last_w[3]), .busy(busy_w[3]), .frame_cnt(frame_cnt_d));

  logic [1:0]  sel = 2'd0;
  logic        cur_in_ready, cur_out_valid, cur_out_last, cur_busy;
  logic [1:0]  cur_out_sym;
  logic [15:0] cur_frame_cnt;

  always_comb begin
    cur_in_ready  = in_ready_w[sel];
    cur_out_valid = out_valid_w[sel];
    cur_out_last  = out_last_w[sel];
    cur_busy      = busy_w[sel];
    cur_out_sym   = out_sym_w[sel];
    case (sel)
      2'd0:    cur_frame_cnt = frame_cnt_a;
      2'd1:    cur_frame_cnt = frame_cnt_b;
      2'd2:    cur_frame_cnt = frame_cnt_c;
      default: cur_frame_cnt = {14'd0, frame_cnt_d};
    endcase
  end

  // ---------------- scoreboard / reference model ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic [2:0] exp_q[$];   // {last, sym}
  logic       frame_q[$];
  logic       took;
  logic       rdy_seen;
  int         rdy_low_cnt;
  int         attempts;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Encoder output at time t: XOR of x[t-j] over taps, where generator bit K-1-j
  // weights the input j steps back; bits before the frame start count as zero.
  function automatic logic [1:0] model_sym(input int t, input int k, input int n, input logic [63:0] g);
    logic [1:0] s;
    logic       acc;
    logic       tap;
    logic       xb;
    s = '0;
    for (int i = 0; i < n; i++) begin
      acc = 1'b0;
      for (int j = 0; j < k; j++) begin
        tap = ((g >> (i * k + k - 1 - j)) & 64'd1) != 64'd0;
        xb  = (t - j >= 0) ? frame_q[t - j] : 1'b0;
        acc = acc ^ (tap & xb);
      end
      s = s | (2'(acc) << i);
    end
    return s;
  endfunction

  task automatic build_expect(input int k, input int n, input logic [63:0] g);
    int len;
    for (int i = 0; i < k - 1; i++) frame_q.push_back(1'b0);
    len = frame_q.size();
    for (int t = 0; t < len; t++) exp_q.push_back({(t == len - 1), model_sym(t, k, n, g)});
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge with inputs already driven; samples, then waits one cycle.
  task automatic step();
    logic [2:0] e;
    #1;
    took     = in_valid && cur_in_ready;
    rdy_seen = cur_in_ready;
    if (cur_out_valid && out_ready) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL extra_symbol: observed %0h expected none", {cur_out_last, cur_out_sym});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("symbol", {29'd0, cur_out_last, cur_out_sym}, {29'd0, e});
      end
    end
    @(negedge clk20M_sig);
  endtask

  task automatic do_reset();
    reset_sig = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    step();
    check("in_ready_in_reset", {31'd0, rdy_seen}, 32'd0);
    step();
    reset_sig = 1'b0;
    out_ready = 1'b1;
    check("reset_out_valid", {31'd0, cur_out_valid}, 32'd0);
    check("reset_out_last", {31'd0, cur_out_last}, 32'd0);
    check("reset_out_sym", {30'd0, cur_out_sym}, 32'd0);
    check("reset_busy", {31'd0, cur_busy}, 32'd0);
    check("reset_frame_cnt", {16'd0, cur_frame_cnt}, 32'd0);
  endtask

  task automatic send_bit(input logic b, input logic last, input bit rnd);
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = last;
    attempts = 0;
    do begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      step();
      attempts++;
    end while (!took && attempts < 200);
    n_cmp++;
    assert (took) else begin
      n_err++;
      $error("FAIL send_timeout: observed not accepted expected accepted");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int ndata, input bit rnd, input bit gaps);
    for (int t = 0; t < ndata; t++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_bit   = 1'($urandom_range(0, 1));
        step();
      end
      send_bit(frame_q[t], (t == ndata - 1), rnd);
    end
  endtask

  task automatic drain(input bit rnd, input int keep);
    int guard;
    guard       = 0;
    rdy_low_cnt = 0;
    while (exp_q.size() > keep && guard < 5000) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
      if (!rdy_seen) rdy_low_cnt++;
      guard++;
    end
    out_ready = 1'b1;
    check("drain_remaining", exp_q.size(), keep);
    if (keep == 0) check("idle_after_frame", {31'd0, cur_out_valid}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    @(negedge clk20M_sig);

    // 1: K=3 (7,5) terminated frame 1,0,1,1.
    sel = 2'd0;
    do_reset();
    exp_q   = '{3'b011, 3'b001, 3'b000, 3'b010, 3'b010, 3'b111};
    frame_q = '{1'b1, 1'b0, 1'b1, 1'b1};
    send_bit(frame_q[0], 1'b0, 1'b0);
    check("busy_mid_frame", {31'd0, cur_busy}, 32'd1);
    send_bit(frame_q[1], 1'b0, 1'b0);
    send_bit(frame_q[2], 1'b0, 1'b0);
    send_bit(frame_q[3], 1'b1, 1'b0);
    drain(1'b0, 0);
    check("tail_in_ready_low", rdy_low_cnt, 2);
    check("t1_frame_cnt", {16'd0, cur_frame_cnt}, 32'd1);
    check("t1_busy_done", {31'd0, cur_busy}, 32'd0);

    // 2: no termination, back-to-back second frame must start from cleared sr.
    sel = 2'd1;
    do_reset();
    exp_q = '{3'b011, 3'b001, 3'b000, 3'b110, 3'b111};
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    check("b2b_first_try", attempts, 1);
    check("b2b_busy_held", {31'd0, cur_busy}, 32'd1);
    drain(1'b0, 0);
    check("t2_frame_cnt", {16'd0, cur_frame_cnt}, 32'd2);

    // 3: backpressure for 5 cycles after the first symbol.
    sel = 2'd0;
    do_reset();
    exp_q = '{3'b011, 3'b001, 3'b000, 3'b010, 3'b010, 3'b111};
    send_bit(1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bit    = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_in_ready", {31'd0, rdy_seen}, 32'd0);
      check("bp_out_valid", {31'd0, cur_out_valid}, 32'd1);
      check("bp_out_sym", {30'd0, cur_out_sym}, 32'd3);
    end
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    drain(1'b0, 0);
    check("t3_frame_cnt", {16'd0, cur_frame_cnt}, 32'd1);

    // 4: reset while the tail is being emitted discards the frame.
    do_reset();
    exp_q = '{3'b011, 3'b001, 3'b000, 3'b010, 3'b010, 3'b111};
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    drain(1'b0, 2);
    reset_sig = 1'b1;
    out_ready = 1'b0;
    step();
    exp_q.delete();
    check("rst_tail_out_valid", {31'd0, cur_out_valid}, 32'd0);
    check("rst_tail_busy", {31'd0, cur_busy}, 32'd0);
    check("rst_tail_frame_cnt", {16'd0, cur_frame_cnt}, 32'd0);
    reset_sig = 1'b0;
    out_ready = 1'b1;
    exp_q = '{3'b011, 3'b001, 3'b000, 3'b010, 3'b010, 3'b111};
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    drain(1'b0, 0);
    check("t4_frame_cnt", {16'd0, cur_frame_cnt}, 32'd1);

    // 5: K=7 (171,133) random 1000-bit frame with random gaps and backpressure.
    sel = 2'd2;
    do_reset();
    frame_q.delete();
    for (int i = 0; i < 1000; i++) frame_q.push_back(1'($urandom_range(0, 1)));
    build_expect(7, 2, 64'(G_C));
    send_frame(1000, 1'b1, 1'b1);
    drain(1'b1, 0);
    check("t5_frame_cnt", {16'd0, cur_frame_cnt}, 32'd1);
    check("t5_busy_done", {31'd0, cur_busy}, 32'd0);

    // 6: 2-bit frame counter wraps after four frames.
    sel = 2'd3;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      frame_q.delete();
      frame_q.push_back(1'($urandom_range(0, 1)));
      build_expect(3, 2, 64'(G_A));
      send_frame(1, 1'b0, 1'b0);
      drain(1'b0, 0);
      check("wrap_frame_cnt", {16'd0, cur_frame_cnt}, (f + 1) % 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
